// File: rtl/axi_tensor_rd_pkg.sv
// Shared types and constants for the tensorcore AXI read path.
package axi_tensor_rd_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // The AR slot struct is sized for the largest supported ID/address;
    // instances use the low bits that match their own parameters.
    localparam int AR_ID_MAX_W   = 8;
    localparam int AR_ADDR_MAX_W = 64;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [AR_ID_MAX_W-1:0]   id;
        logic [AR_ADDR_MAX_W-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
    } ar_req_t;

endpackage

// File: rtl/axi_tensor_rd_mc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when the grant is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Scan requesters starting at the pointer, wrapping modulo N
    always_comb begin
        gnt       = '0;
        found_s   = 1'b0;
        ptr_nxt_s = ptr_r;
        idx_s     = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = PW'((int'(ptr_r) + i) % N);
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
                ptr_nxt_s  = (int'(idx_s) == N - 1) ? '0 : PW'(int'(idx_s) + 1);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer update: only a consumed grant moves it; no grant leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/axi_tensor_rd_mc.sv
// Multi-channel AXI4 read master: round-robin AR issue with ARID = channel,
// per-channel outstanding limits, and RID-steered R beats with beat numbering.
module axi_tensor_rd_mc
    import axi_tensor_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_CH     = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    output logic [ID_WIDTH-1:0]      m_axi_arid,
    output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
    output logic [7:0]               m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic [1:0]               m_axi_arburst,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [ID_WIDTH-1:0]      m_axi_rid,
    input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*8-1:0]      req_len,
    input  logic [NUM_CH*3-1:0]      req_size,
    output logic [NUM_CH-1:0]        rsp_valid,
    input  logic [NUM_CH-1:0]        rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_last,
    output logic [7:0]               rsp_beat,
    output logic                     rsp_err,
    output logic                     err_bad_id,
    output logic                     busy
);

    localparam int OW = $clog2(MAX_OUTST + 1);

    ar_req_t           slot_r;
    ar_req_t           slot_nxt_s;
    logic              slot_vld_r;
    logic [OW-1:0]     outst_r [NUM_CH];
    logic [7:0]        beat_r  [NUM_CH];
    logic              err_bad_id_r;

    logic              can_load_s;
    logic              load_s;
    logic              ar_hs_s;
    logic              r_hs_s;
    logic              rid_ok_s;
    logic              any_outst_s;
    logic [NUM_CH-1:0] elig_s;
    logic [NUM_CH-1:0] gnt_s;
    logic [NUM_CH-1:0] inc_s;
    logic [NUM_CH-1:0] dec_s;
    logic [NUM_CH-1:0] r_hit_s;
    logic              unused_slot_s;

    assign ar_hs_s    = slot_vld_r && m_axi_arready;
    assign can_load_s = !slot_vld_r || m_axi_arready;
    assign load_s     = can_load_s && (|gnt_s);
    assign rid_ok_s   = int'(m_axi_rid) < NUM_CH;
    assign r_hs_s     = m_axi_rvalid && m_axi_rready;

    // Eligibility counts a burst still parked in the AR slot as in flight,
    // otherwise a channel could win once more before its counter catches up.
    always_comb begin
        elig_s      = '0;
        any_outst_s = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig_s[c] = req_valid[c] &&
                        ((int'(outst_r[c]) +
                          ((slot_vld_r && (slot_r.id == AR_ID_MAX_W'(c))) ? 1 : 0)) < MAX_OUTST);
            if (outst_r[c] != '0) begin
                any_outst_s = 1'b1;
            end else begin
                any_outst_s = any_outst_s;
            end
        end
    end

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (aclk),
        .rst_n   (aresetn),
        .req     (elig_s),
        .advance (can_load_s),
        .gnt     (gnt_s)
    );

    assign req_ready = gnt_s & {NUM_CH{can_load_s}};

    // Gather the granted channel's request fields into the next slot value
    always_comb begin
        slot_nxt_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_s[c]) begin
                slot_nxt_s.id   = AR_ID_MAX_W'(c);
                slot_nxt_s.addr = AR_ADDR_MAX_W'(req_addr[c*ADDR_WIDTH +: ADDR_WIDTH]);
                slot_nxt_s.len  = req_len[c*8 +: 8];
                slot_nxt_s.size = req_size[c*3 +: 3];
            end else begin
                slot_nxt_s = slot_nxt_s;
            end
        end
    end

    // AR slot: loads when empty or draining, fields frozen while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            slot_r     <= '0;
            slot_vld_r <= 1'b0;
        end else if (load_s) begin
            slot_r     <= slot_nxt_s;
            slot_vld_r <= 1'b1;
        end else if (ar_hs_s) begin
            slot_vld_r <= 1'b0;
        end else begin
            slot_vld_r <= slot_vld_r;
        end
    end

    // Steer the R beat to its owner; unknown IDs are swallowed
    always_comb begin
        r_hit_s      = '0;
        rsp_beat     = 8'd0;
        m_axi_rready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rid_ok_s && (m_axi_rid == ID_WIDTH'(c))) begin
                r_hit_s[c]   = 1'b1;
                rsp_beat     = beat_r[c];
                m_axi_rready = rsp_ready[c];
            end else begin
                r_hit_s[c] = 1'b0;
            end
        end
    end

    assign inc_s = {NUM_CH{ar_hs_s}} & slot_onehot(slot_r.id);
    assign dec_s = {NUM_CH{r_hs_s && m_axi_rlast}} & r_hit_s;

    function automatic logic [NUM_CH-1:0] slot_onehot(input logic [AR_ID_MAX_W-1:0] id);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            oh[c] = (id == AR_ID_MAX_W'(c));
        end
        return oh;
    endfunction

    // Per-channel outstanding bursts, saturating at both ends
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < NUM_CH; c++) outst_r[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case ({inc_s[c], dec_s[c]})
                    2'b10: outst_r[c] <= (outst_r[c] < OW'(MAX_OUTST)) ? outst_r[c] + OW'(1) : outst_r[c];
                    2'b01: outst_r[c] <= (outst_r[c] != '0) ? outst_r[c] - OW'(1) : outst_r[c];
                    default: outst_r[c] <= outst_r[c];
                endcase
            end
        end
    end

    // Per-channel beat index, cleared by the burst's last beat
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < NUM_CH; c++) beat_r[c] <= 8'd0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_hs_s && r_hit_s[c]) begin
                    beat_r[c] <= m_axi_rlast ? 8'd0 : beat_r[c] + 8'd1;
                end else begin
                    beat_r[c] <= beat_r[c];
                end
            end
        end
    end

    // Sticky flag for beats whose RID maps to no channel
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_bad_id_r <= 1'b0;
        end else if (m_axi_rvalid && !rid_ok_s) begin
            err_bad_id_r <= 1'b1;
        end else begin
            err_bad_id_r <= err_bad_id_r;
        end
    end

    assign m_axi_arid    = slot_r.id[ID_WIDTH-1:0];
    assign m_axi_araddr  = slot_r.addr[ADDR_WIDTH-1:0];
    assign m_axi_arlen   = slot_r.len;
    assign m_axi_arsize  = slot_r.size;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = slot_vld_r;

    assign rsp_valid  = r_hit_s & {NUM_CH{m_axi_rvalid}};
    assign rsp_data   = m_axi_rdata;
    assign rsp_last   = m_axi_rlast;
    assign rsp_err    = (axi_resp_e'(m_axi_rresp) != OKAY);
    assign err_bad_id = err_bad_id_r;
    assign busy       = slot_vld_r || any_outst_s;

    // Slot padding bits above the configured widths are always zero
    assign unused_slot_s = ^{slot_r.id, slot_r.addr};

endmodule
